// File: rtl/i2c_master_byte_ctrl.sv
// Byte sequencer for i2c_master_phy: expands byte requests into bit commands.
// Optional per-command watchdog enabled by defining I2C_CTRL_TIMEOUT_EN.
package i2c_master_pkg;
    typedef enum logic [2:0] {
        CMD_IDLE  = 3'd0,
        CMD_START = 3'd1,
        CMD_STOP  = 3'd2,
        CMD_WRITE = 3'd3,
        CMD_READ  = 3'd4
    } phy_cmd_e;
endpackage

module i2c_master_byte_ctrl
    import i2c_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_start_i,
    input  logic       req_stop_i,
    input  logic       req_read_i,
    input  logic       req_nodata_i,
    input  logic       req_nack_i,
    input  logic [7:0] req_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic       rsp_ack_o,
    output logic       rsp_arb_lost_o,
    output logic       rsp_timeout_o,
    output logic       bus_owned_o,
    output logic [2:0] phy_cmd_o,
    output logic       phy_data_o,
    input  logic       phy_data_i,
    input  logic       phy_cmd_done_i,
    input  logic       phy_arb_lost_i,
    input  logic       phy_bus_busy_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BUS,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_DRAIN,
        S_RESP
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       stop_q, stop_d;
    logic       read_q, read_d;
    logic       nodata_q, nodata_d;
    logic       nack_q, nack_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ack_q, ack_d;
    logic       arb_q, arb_d;
    logic       to_q, to_d;
    logic       owned_q, owned_d;
    logic       ready_q;
    phy_cmd_e   cmd_q, cmd_d;
    logic       pdata_q, pdata_d;
    logic       accept;
    logic       active;
    logic       wd_hit;

    assign accept = req_valid_i && ready_q;
    assign active = state_q inside {S_WAIT_BUS, S_START, S_BIT, S_ACK, S_STOP};

`ifdef I2C_CTRL_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q;
    logic            wd_run;

    assign wd_run = state_q inside {S_START, S_BIT, S_ACK, S_STOP, S_DRAIN};
    assign wd_hit = wd_run && !phy_cmd_done_i && (wd_q == WD_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_q <= '0;
        end else if (!wd_run || phy_cmd_done_i || wd_hit) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign wd_hit         = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        stop_d    = stop_q;
        read_d    = read_q;
        nodata_d  = nodata_q;
        nack_d    = nack_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ack_d     = ack_q;
        arb_d     = arb_q;
        to_d      = to_q;
        owned_d   = owned_q;
        cmd_d     = CMD_IDLE;
        pdata_d   = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    stop_d    = req_stop_i;
                    read_d    = req_read_i;
                    nodata_d  = req_nodata_i;
                    nack_d    = req_nack_i;
                    wdata_d   = req_wdata_i;
                    rdata_d   = 8'h00;
                    ack_d     = 1'b0;
                    arb_d     = 1'b0;
                    to_d      = 1'b0;
                    bit_cnt_d = 3'd7;
                    if (req_start_i && !owned_q && phy_bus_busy_i) begin
                        state_d = S_WAIT_BUS;
                    end else if (req_start_i) begin
                        state_d = S_START;
                    end else if (!req_nodata_i) begin
                        state_d = S_BIT;
                    end else if (req_stop_i) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT_BUS: begin
                if (!phy_bus_busy_i) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (phy_cmd_done_i) begin
                    owned_d = 1'b1;
                    if (!nodata_q) begin
                        state_d = S_BIT;
                    end else begin
                        state_d = stop_q ? S_STOP : S_RESP;
                    end
                end
            end
            S_BIT: begin
                if (phy_cmd_done_i) begin
                    if (read_q) begin
                        rdata_d = {rdata_q[6:0], phy_data_i};
                    end
                    if (bit_cnt_q == 3'd0) begin
                        state_d = S_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end
            end
            S_ACK: begin
                if (phy_cmd_done_i) begin
                    if (!read_q) begin
                        ack_d = phy_data_i;
                    end
                    state_d = stop_q ? S_STOP : S_RESP;
                end
            end
            S_STOP: begin
                if (phy_cmd_done_i) begin
                    owned_d = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_DRAIN: begin
                if (phy_cmd_done_i) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (wd_hit) begin
            to_d    = 1'b1;
            owned_d = 1'b0;
            state_d = S_RESP;
        end

        // No command is in flight while waiting for the bus, so skip the drain.
        if (phy_arb_lost_i && active) begin
            arb_d   = 1'b1;
            owned_d = 1'b0;
            if (phy_cmd_done_i || state_q == S_WAIT_BUS) begin
                state_d = S_RESP;
            end else begin
                state_d = S_DRAIN;
            end
        end

        unique case (1'b1)
            state_d == S_START: cmd_d = CMD_START;
            state_d == S_STOP:  cmd_d = CMD_STOP;
            state_d == S_BIT && read_d: cmd_d = CMD_READ;
            state_d == S_BIT && !read_d: begin
                cmd_d   = CMD_WRITE;
                pdata_d = wdata_d[bit_cnt_d];
            end
            state_d == S_ACK && read_d: begin
                cmd_d   = CMD_WRITE;
                pdata_d = nack_d;
            end
            state_d == S_ACK && !read_d: cmd_d = CMD_READ;
            default: cmd_d = CMD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 3'd7;
            stop_q    <= 1'b0;
            read_q    <= 1'b0;
            nodata_q  <= 1'b0;
            nack_q    <= 1'b0;
            wdata_q   <= 8'h00;
            rdata_q   <= 8'h00;
            ack_q     <= 1'b0;
            arb_q     <= 1'b0;
            to_q      <= 1'b0;
            owned_q   <= 1'b0;
            ready_q   <= 1'b0;
            cmd_q     <= CMD_IDLE;
            pdata_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            stop_q    <= stop_d;
            read_q    <= read_d;
            nodata_q  <= nodata_d;
            nack_q    <= nack_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            arb_q     <= arb_d;
            to_q      <= to_d;
            owned_q   <= owned_d;
            ready_q   <= (state_d == S_IDLE);
            cmd_q     <= cmd_d;
            pdata_q   <= pdata_d;
        end
    end

    assign req_ready_o    = ready_q;
    assign rsp_valid_o    = (state_q == S_RESP);
    assign rsp_rdata_o    = rdata_q;
    assign rsp_ack_o      = ack_q;
    assign rsp_arb_lost_o = arb_q;
    assign rsp_timeout_o  = to_q;
    assign bus_owned_o    = owned_q;
    assign phy_cmd_o      = cmd_q;
    assign phy_data_o     = pdata_q;

endmodule

// File: doc/i2c_master_byte_ctrl.md
# i2c_master_byte_ctrl

Byte-level sequencer for `i2c_master_phy`. It accepts one byte transaction per request, optionally with START and/or STOP, and expands it into the phy's per-bit START/STOP/READ/WRITE commands. It also tracks bus ownership and reports received data, the ACK bit, arbitration loss and timeout on a single response strobe. It sits between the register/host interface and the phy; the phy uses the same clock and reset.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1_000_000: clk_i cycles allowed per phy bit command before abort (used only with `I2C_CTRL_TIMEOUT_EN`).

Ports:
- `clk_i` input 1: clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `req_valid_i` input 1: request valid.
- `req_ready_o` output 1: request accepted when `req_valid_i && req_ready_o`.
- `req_start_i` input 1: issue START (repeated START if the bus is already owned) before the byte.
- `req_stop_i` input 1: issue STOP after the byte.
- `req_read_i` input 1: 1 = read byte, 0 = write byte.
- `req_nodata_i` input 1: skip the byte phase (START/STOP only).
- `req_nack_i` input 1: bit the master sends after a read byte (1 = NACK).
- `req_wdata_i` input 8: write byte, transmitted MSB first.
- `rsp_valid_o` output 1: one-cycle response strobe.
- `rsp_rdata_o` output 8: received byte.
- `rsp_ack_o` output 1: ACK bit sampled after a write (0 = acked).
- `rsp_arb_lost_o` output 1: transaction aborted, arbitration lost.
- `rsp_timeout_o` output 1: transaction aborted, timeout.
- `bus_owned_o` output 1: we hold the bus (between our START and our STOP).
- `phy_cmd_o` output 3: command to phy (`i2c_master_pkg` codes; `IDLE` = none).
- `phy_data_o` output 1: bit to write.
- `phy_data_i` input 1: bit read.
- `phy_cmd_done_i` input 1: phy bit command complete.
- `phy_arb_lost_i` input 1: phy arbitration-loss pulse.
- `phy_bus_busy_i` input 1: bus busy between START and STOP.

## Operation
- States:
  - `IDLE`
  - `WAIT_BUS`
  - `START`
  - `BIT`
  - `ACK`
  - `STOP`
  - `DRAIN`
  - `RESP`
- `IDLE`: `req_ready_o`=1. On acceptance, latch all request fields. Next state:
  - start requested, bus not owned, `phy_bus_busy_i`=1 -> `WAIT_BUS`;
  - start requested otherwise -> `START`;
  - `nodata`=0 -> `BIT`;
  - `stop` -> `STOP`;
  - else -> `RESP`.
- `WAIT_BUS`: stay until `phy_bus_busy_i`=0, then `START`.
- `START`/`STOP`: `phy_cmd_o`=START/STOP until `phy_cmd_done_i`.
  - START done sets `bus_owned_o`; STOP done clears it.
- `BIT`: 8 iterations, 3-bit counter `bit_cnt` from 7 down to 0.
  - Write: `phy_cmd_o`=WRITE, `phy_data_o`=`wdata[bit_cnt]`.
  - Read: `phy_cmd_o`=READ; on done, shift `phy_data_i` into `rdata` LSB.
  - Advance on each `phy_cmd_done_i`; after bit 0 -> `ACK`.
- `ACK`:
  - Write: READ command; on done, `rsp_ack_o` <= `phy_data_i`.
  - Read: WRITE command with `phy_data_o`=`req_nack_i`.
  - Then `STOP` if requested, else `RESP`.
- A write with ACK=1 still proceeds to STOP if requested; the host decides retries.
- `phy_arb_lost_i` in any active state:
  - set the arb flag, `phy_cmd_o` <= IDLE, clear `bus_owned_o`;
  - -> `DRAIN` (wait for `phy_cmd_done_i` of the in-flight bit), then `RESP`.
- `RESP`: `rsp_valid_o`=1 for one cycle with the flags, then `IDLE`. Flags are cleared on the next acceptance.
- Simultaneous `phy_cmd_done_i` and `phy_arb_lost_i`: arbitration loss wins; go straight to `RESP`.

## Timing
- Reset values:
  - `req_ready_o`=0 during reset, then 1 in `IDLE`;
  - `rsp_*`=0, `bus_owned_o`=0;
  - `phy_cmd_o`=IDLE, `phy_data_o`=1.
- `phy_cmd_o`/`phy_data_o` are registered.
  - They are updated the cycle after acceptance, or in the cycle after each `phy_cmd_done_i`, to the next command or IDLE.
  - They are held stable for the whole bit.
  - The phy samples a command only at its next state boundary, so a command updated on the done cycle is never double-issued.
- `phy_data_i` is sampled in the `phy_cmd_done_i` cycle.
- `rsp_valid_o` asserts exactly 1 cycle after the final `phy_cmd_done_i`.
- Back-to-back requests: the next request is accepted the cycle after `rsp_valid_o`.
- Reset mid-transaction: immediate return to reset values; the phy is reset simultaneously, so no STOP is issued.

## Configuration
- `I2C_CTRL_TIMEOUT_EN` defined:
  - a `$clog2(TIMEOUT_CYCLES+1)`-bit counter runs while a phy command is outstanding and resets on each `phy_cmd_done_i`;
  - reaching `TIMEOUT_CYCLES`: set `rsp_timeout_o`, set `phy_cmd_o`=IDLE, clear `bus_owned_o`, go to `RESP` without draining.
- `I2C_CTRL_TIMEOUT_EN` undefined: no counter; `rsp_timeout_o` is tied 0; a stretched SCL waits indefinitely.

## Test plan
- Write with start=1, stop=1, wdata=0xA5, slave ACKs -> phy sees START, WRITE×8 with data 1,0,1,0,0,1,0,1, READ, STOP; rsp_ack_o=0; bus_owned_o 1 then 0.
- Read with start=0, nack=1 while owned, slave bits 0x3C -> 8 READ then WRITE data=1; rsp_rdata_o=0x3C.
- Start request while `phy_bus_busy_i`=1 and not owned -> no START until busy falls; then normal completion.
- `phy_arb_lost_i` pulse during bit 5 of a write -> no further commands after the current done; rsp_arb_lost_o=1; bus_owned_o=0.
- nodata=1, stop=1 -> only STOP issued; response 1 cycle after done.
- With `I2C_CTRL_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100, `phy_cmd_done_i` withheld -> rsp_timeout_o=1 at cycle 100 after issue.
